// File: rtl/std_fp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : std_fp_div_seq                                                |
// | Function : sequential unsigned fixed-point divider, one quotient bit per |
// |            cycle, go/done handshake: out = (left << FRACT_WIDTH) / right |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module std_fp_div_seq #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_remainder,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             done
);

  localparam int N     = WIDTH + FRACT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_width_check
    $error("std_fp_div_seq: INT_WIDTH + FRACT_WIDTH must equal WIDTH");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_dq;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_right;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_out_rem;
  logic             r_ovf;
  logic             r_dbz;
  logic             w_done;

  logic             w_last;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [N-1:0]     w_dq_next;

  // r_dq holds the unconsumed dividend in its upper bits; quotient bits fill in from the LSB
  assign w_last      = (r_cnt == c_LAST);
  assign w_rem_shift = {r_rem, r_dq[N-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_right});
  assign w_rem_next  = w_ge ? WIDTH'(w_rem_shift - {1'b0, r_right})
                            : w_rem_shift[WIDTH-1:0];
  assign w_dq_next   = {r_dq[N-2:0], w_ge};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (go) begin
          w_next_state = (right == '0) ? c_DONE : c_BUSY;
        end
      end
      c_BUSY: begin
        if (w_last) begin
          w_next_state = c_DONE;
        end
      end
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_done = 1'b0;
    if (r_state == c_DONE) begin
      w_done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_dq      <= '0;
      r_rem     <= '0;
      r_right   <= '0;
      r_out     <= '0;
      r_out_rem <= '0;
      r_ovf     <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (go) begin
            r_right <= right;
            if (right == '0) begin
              r_out     <= '1;
              r_out_rem <= left;
              r_ovf     <= 1'b0;
              r_dbz     <= 1'b1;
            end else begin
              r_cnt <= '0;
              r_dq  <= {left, {FRACT_WIDTH{1'b0}}};
              r_rem <= '0;
            end
          end
        end
        c_BUSY: begin
          r_dq  <= w_dq_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + CNT_W'(1);
          // Visible results change only on the final iteration
          if (w_last) begin
            r_out     <= w_dq_next[WIDTH-1:0];
            r_out_rem <= w_rem_next;
            r_ovf     <= |w_dq_next[N-1:WIDTH];
            r_dbz     <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out           = r_out;
  assign out_remainder = r_out_rem;
  assign overflow      = r_ovf;
  assign div_by_zero   = r_dbz;
  assign done          = w_done;

endmodule
`default_nettype wire
